sqrt_iter: RTL and testbench

Sequential integer square-root unit: the inverse path of the fast squarer. It accepts an unsigned squared magnitude of up to 17 bits and returns the floor root and the remainder, resolving one root bit per clock with a digit-by-digit restoring algorithm. It sits downstream of squared-error and energy accumulators, where an RMS or magnitude is needed in the original 9-bit sample domain. Both sides use a valid/ready handshake so the unit can sit between pipelined producers and consumers.

---
 rtl/fast_square_pkg.sv | 17 +
 rtl/sqrt_iter_if.sv | 22 ++
 rtl/sqrt_iter_step.sv | 23 ++
 rtl/sqrt_iter.sv | 97 +++++++++
 tb/tb_sqrt_iter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fast_square_pkg.sv
// Shared constants and types for the squarer / square-root family.
// Optional build macro: SQRT_ROUND_EN (round-to-nearest root in sqrt_iter).
package fast_square_pkg;

   localparam int SQR_W  = 17;
   localparam int ROOT_W = (SQR_W + 1) / 2;
   // Partial remainder needs two guard bits above the root width to absorb the shift-in.
   localparam int REM_W  = ROOT_W + 2;
   localparam int CNT_W  = $clog2(ROOT_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sqrt_state_t;

endpackage

// File: rtl/sqrt_iter_if.sv
// Valid/ready handshake bundle between a producer/consumer and sqrt_iter.
interface sqrt_iter_if;
   import fast_square_pkg::*;

   logic [SQR_W-1:0]  i_sqr;
   logic              i_valid;
   logic              o_ready;
   logic [ROOT_W-1:0] o_root;
   logic [ROOT_W:0]   o_rem;
   logic              o_valid;
   logic              i_ready;

   modport master (
      output i_sqr, i_valid, i_ready,
      input  o_ready, o_root, o_rem, o_valid
   );

   modport slave (
      input  i_sqr, i_valid, i_ready,
      output o_ready, o_root, o_rem, o_valid
   );
endinterface

// File: rtl/sqrt_iter_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
module sqrt_step
   import fast_square_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        bits,
   output logic [REM_W-1:0]  rem_next,
   output logic [ROOT_W-1:0] root_next
);

   logic [REM_W-1:0] r_shift;
   logic [REM_W-1:0] trial;
   logic             fits;

   assign r_shift = (rem << 2) | {{(REM_W-2){1'b0}}, bits};
   assign trial   = {root, 2'b01};
   assign fits    = (r_shift >= trial);

   assign rem_next  = fits ? (r_shift - trial) : r_shift;
   assign root_next = {root[ROOT_W-2:0], fits};

endmodule

// File: rtl/sqrt_iter.sv
// Sequential integer square root, one root bit per clock, valid/ready on both sides.
// Optional build macro: SQRT_ROUND_EN rounds the reported root to nearest.
module sqrt_iter
   import fast_square_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   sqrt_iter_if.slave bus
);

   sqrt_state_t         state;
   sqrt_state_t         state_next;
   logic [2*ROOT_W-1:0] shreg;
   logic [REM_W-1:0]    rem_q;
   logic [ROOT_W-1:0]   root_q;
   logic [CNT_W-1:0]    cnt;
   logic [REM_W-1:0]    rem_next;
   logic [ROOT_W-1:0]   root_next;
   logic [ROOT_W-1:0]   root_out;
   logic [ROOT_W:0]     rem_out;
   logic                ready_c;
   logic                valid_c;

   sqrt_step u_step (
      .rem       (rem_q),
      .root      (root_q),
      .bits      (shreg[2*ROOT_W-1 -: 2]),
      .rem_next  (rem_next),
      .root_next (root_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.i_valid) state_next = BUSY;
         BUSY:    if (cnt == '0)   state_next = DONE;
         DONE:    if (bus.i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_c = (state == IDLE);
      valid_c = (state == DONE);
   end

   // Result registers load only on the last iteration and hold through the next IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         cnt      <= '0;
         root_out <= '0;
         rem_out  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.i_valid) begin
               shreg  <= (2*ROOT_W)'(bus.i_sqr);
               rem_q  <= '0;
               root_q <= '0;
               cnt    <= CNT_W'(ROOT_W - 1);
            end
            BUSY: begin
               shreg  <= shreg << 2;
               rem_q  <= rem_next;
               root_q <= root_next;
               if (cnt == '0) begin
                  rem_out <= rem_next[ROOT_W:0];
`ifdef SQRT_ROUND_EN
                  if (rem_next > REM_W'(root_next))
                     root_out <= (&root_next) ? root_next : root_next + 1'b1;
                  else
                     root_out <= root_next;
`else
                  root_out <= root_next;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready = ready_c;
   assign bus.o_valid = valid_c;
   assign bus.o_root  = root_out;
   assign bus.o_rem   = rem_out;

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: directed corner cases plus random radicands vs. an arithmetic model.
module tb_sqrt_iter;
   import fast_square_pkg::*;

   typedef struct {
      int sqr;
      int root;
      int rem;
   } exp_t;

   logic clk;
   logic rst;
   sqrt_iter_if bus ();

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   sqrt_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Reference: floor root by plain search, optional nearest-integer rounding by distance.
   function automatic exp_t model(input int x);
      exp_t e;
      int   r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      e.sqr  = x;
      e.rem  = x - r * r;
      e.root = r;
`ifdef SQRT_ROUND_EN
      if ((x - r * r) > ((r + 1) * (r + 1) - x)) e.root = r + 1;
`endif
      return e;
   endfunction

   task automatic applyStimulus(input int x);
      int waited = 0;
      @(negedge clk);
      while (!bus.o_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.o_ready) checkOutput("accept_timeout", 0, 1);
      bus.i_sqr   = SQR_W'(x);
      bus.i_valid = 1'b1;
      exp_q.push_back(model(x));
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while ((exp_q.size() != 0 || bus.o_valid) && cyc < 500) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      checkOutput("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: every handshake completion pops one expected result.
   always @(negedge clk) begin
      if (!rst && bus.o_valid && bus.i_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", int'(bus.o_root), -1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("root(%0d)", e.sqr), int'(bus.o_root), e.root);
            checkOutput($sformatf("rem(%0d)", e.sqr), int'(bus.o_rem), e.rem);
         end
      end
   end

   initial begin
      int k;
      int edge_vals[6];
      bus.i_sqr   = '0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      rst         = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_ready", int'(bus.o_ready), 1);
      checkOutput("reset_valid", int'(bus.o_valid), 0);
      checkOutput("reset_root", int'(bus.o_root), 0);
      checkOutput("reset_rem", int'(bus.o_rem), 0);

      applyStimulus(0);
      k = 1;
      @(posedge clk);
      #1;
      while (!bus.o_valid && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      checkOutput("latency", k, ROOT_W);
      drain();

      edge_vals = '{100, 131044, 131071, 99, 1, 3};
      foreach (edge_vals[i]) applyStimulus(edge_vals[i]);
      drain();

      // Backpressure: result must hold while stray i_valid pulses are ignored.
      bus.i_ready = 1'b0;
      applyStimulus(50);
      k = 0;
      while (!bus.o_valid && k < 30) begin
         @(posedge clk);
         #1;
         k++;
      end
      for (int c = 0; c < 20; c++) begin
         bus.i_sqr   = SQR_W'($urandom);
         bus.i_valid = c[0];
         @(negedge clk);
         checkOutput("bp_valid", int'(bus.o_valid), 1);
         checkOutput("bp_ready", int'(bus.o_ready), 0);
         checkOutput("bp_root", int'(bus.o_root), 7);
         checkOutput("bp_rem", int'(bus.o_rem), 1);
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      drain();

      // Reset four cycles into a computation discards it.
      applyStimulus(400);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_ready", int'(bus.o_ready), 1);
      checkOutput("midrst_valid", int'(bus.o_valid), 0);
      checkOutput("midrst_root", int'(bus.o_root), 0);
      repeat (15) @(posedge clk);
      applyStimulus(400);
      drain();

      for (int n = 0; n < 2000; n++) applyStimulus(int'($urandom_range(0, (1 << SQR_W) - 1)));
      drain();

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
